program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter WORD_STEP, default 4, giving the byte-address increment between consecutive loaded words.
REQ-002 The block SHALL have parameter MAX_WORDS, default 1024, giving the largest legal word count per block.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port rx_data  input  8  incoming loader byte stream.
REQ-006 Port rx_valid  input  1  rx_data is valid this cycle.
REQ-007 Port rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 Port imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 Port imem_addr  output  32  instruction-memory byte address.
REQ-010 Port imem_wdata  output  32  instruction word.
REQ-011 Port dmem_we  output  1  data-memory write strobe, one cycle per word.
REQ-012 Port dmem_addr  output  32  data-memory byte address.
REQ-013 Port dmem_wdata  output  32  data word.
REQ-014 Port core_hold  output  1  holds the pipeline stalled with the PC frozen while high.
REQ-015 Port start_pc  output  32  PC value the core loads on release.
REQ-016 Port load_done  output  1  high once a GO frame has been accepted.
REQ-017 Port load_error  output  1  sticky protocol or checksum error.

Function
REQ-018 A byte transfers only on a rising edge with rx_valid=1 and rx_ready=1.
REQ-019 rx_ready SHALL be 1 in IDLE, ADDR, COUNT, DATA, CSUM and PC, and 0 in RUN and ERROR.
REQ-020 States SHALL be IDLE, ADDR, COUNT, DATA, CSUM, PC, RUN and ERROR.
REQ-021 IDLE accepts a command byte: 0xA5 selects an instruction block, 0x5A a data block, 0x3C GO; any other value goes to ERROR.
REQ-022 For a block, ADDR takes 4 bytes of base address MSB first, then COUNT takes 2 bytes of word count N MSB first.
REQ-023 N=0 goes directly to CSUM; N>MAX_WORDS goes to ERROR after the second count byte.
REQ-024 DATA takes N*4 bytes; each group of 4 bytes forms one word MSB first.
REQ-025 On the cycle after the 4th byte of word k is accepted, the selected memory SHALL see we=1 for exactly one cycle, with addr = base + k*WORD_STEP (modulo 2^32) and wdata = the assembled word.
REQ-026 The non-selected memory's we SHALL stay 0 throughout a block.
REQ-027 Byte acceptance SHALL continue during the write cycle, with no bubble.
REQ-028 CSUM takes 1 byte, which must equal the XOR of all address, count and data bytes of the block.
REQ-029 On a checksum match the FSM returns to IDLE; on a mismatch it goes to ERROR. Words already written are not rolled back.
REQ-030 For GO, PC takes 4 bytes MSB first; start_pc updates when the 4th byte is accepted, and the FSM enters RUN on the next edge.
REQ-031 In RUN, core_hold=0 and load_done=1; the FSM remains in RUN until reset.
REQ-032 In ERROR, load_error=1 and core_hold=1; the FSM remains in ERROR until reset.
REQ-033 In all states other than RUN, core_hold=1.
REQ-034 Gaps in rx_valid at any byte position SHALL have no effect on the state or on partial-word or checksum accumulation.
REQ-035 Multiple blocks of either type, in any order, are permitted before GO.

Reset
REQ-036 While rst_n=0 at a rising edge, the FSM SHALL go to IDLE and all counters and accumulators SHALL clear.
REQ-037 Output reset values: rx_ready=1, core_hold=1, start_pc=0, load_done=0, load_error=0, imem_we=0, dmem_we=0; all address and data outputs 0.
REQ-038 A reset mid-frame or mid-word SHALL discard the partial frame; no write strobe fires on the cycle after reset.

Verification
REQ-039 Instruction block base=0x00000328, N=2, words 0x20080002, 0x20090002, correct checksum -> imem_we pulses at 0x328 then 0x32C with those words; dmem_we stays 0; FSM returns to IDLE.
REQ-040 GO with 0x00000328 -> start_pc=808, load_done=1 and core_hold=0 one cycle after the last byte; rx_ready=0 thereafter.
REQ-041 Data block base=0, N=1, word 0x0000001A, with a wrong checksum -> dmem_we pulses once at addr 0 with 0x1A; load_error=1; core_hold stays 1; further bytes are ignored.
REQ-042 Command byte 0x77 -> ERROR immediately; load_error=1 and no write strobes.
REQ-043 Data block with base=0xFFFFFFFC and N=2 -> writes at 0xFFFFFFFC then 0x00000000; N=0 with checksum 0xFF^0xFF^0xFF^0xFC -> no writes, IDLE.
REQ-044 rst_n low after the 2nd data byte, then a full valid block -> no spurious write; the block loads correctly; random rx_valid gaps give an identical result.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: byte-stream boot loader that fills instruction/data memories, then releases the core at a start PC.
// Ports: clk, rst_n (synchronous, active-low); rx_data/rx_valid/rx_ready byte stream in;
//        imem_we/imem_addr/imem_wdata and dmem_we/dmem_addr/dmem_wdata one-cycle word writes;
//        core_hold/start_pc core stall and release PC; load_done/load_error status.
module program_loader #(
   parameter int WORD_STEP = 4,
   parameter int MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        core_hold,
   output logic [31:0] start_pc,
   output logic        load_done,
   output logic        load_error
);
   typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, CSUM, PC, RUN, ERROR} state_t;
   state_t      state, state_nx;
   logic [1:0]  cnt;
   logic [31:0] sh, sh_nx, waddr;
   logic [15:0] rem;
   logic [7:0]  csum;
   logic        sel_d, take, last;

   assign take       = rx_valid & rx_ready;
   assign last       = cnt == 2'd3;
   assign sh_nx      = {sh[23:0], rx_data};
   assign core_hold  = state != RUN;
   assign load_done  = state == RUN;
   assign load_error = state == ERROR;

   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      rx_ready = state != RUN && state != ERROR;
      state_nx = state;
      if (take)
         case (state)
            IDLE:    state_nx = (rx_data == 8'hA5 || rx_data == 8'h5A) ? ADDR : (rx_data == 8'h3C) ? PC : ERROR;
            ADDR:    state_nx = last ? COUNT : ADDR;
            COUNT:   state_nx = !cnt[0] ? COUNT : (sh_nx[15:0] == 16'd0) ? CSUM :
                                (32'(sh_nx[15:0]) > 32'(MAX_WORDS)) ? ERROR : DATA;
            DATA:    state_nx = (last && rem == 16'd1) ? CSUM : DATA;
            CSUM:    state_nx = (rx_data == csum) ? IDLE : ERROR;
            PC:      state_nx = last ? RUN : PC;
            default: state_nx = state;
         endcase
   end

   // cnt restarts on every state change, so it tracks the byte position within the current field/word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         sh         <= '0;
         waddr      <= '0;
         rem        <= '0;
         csum       <= '0;
         sel_d      <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         start_pc   <= '0;
      end else begin
         imem_we <= 1'b0;
         dmem_we <= 1'b0;
         if (take) begin
            cnt  <= (state_nx != state) ? 2'd0 : cnt + 2'd1;
            sh   <= sh_nx;
            csum <= (state == IDLE) ? 8'd0 : csum ^ rx_data;
            if (state == IDLE) sel_d <= rx_data == 8'h5A;
            if (state == ADDR && last) waddr <= sh_nx;
            if (state == COUNT) rem <= sh_nx[15:0];
            if (state == DATA && last) begin
               if (sel_d) begin
                  dmem_we    <= 1'b1;
                  dmem_addr  <= waddr;
                  dmem_wdata <= sh_nx;
               end else begin
                  imem_we    <= 1'b1;
                  imem_addr  <= waddr;
                  imem_wdata <= sh_nx;
               end
               waddr <= waddr + 32'(WORD_STEP);
               rem   <= rem - 16'd1;
            end
            if (state == PC && last) start_pc <= sh_nx;
         end
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader.
module tb_program_loader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready, imem_we, dmem_we, core_hold, load_done, load_error;
   logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata, start_pc;
   int          passed = 0;
   int          total = 0;
   bit          gaps = 1'b0;
   logic [7:0]  seq[$];
   logic [63:0] iq[$];
   logic [63:0] dq[$];

   program_loader dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .core_hold(core_hold), .start_pc(start_pc), .load_done(load_done), .load_error(load_error)
   );

   always #5 clk = ~clk;

   // every cycle a strobe is high becomes one log entry, so a stretched strobe shows up as an extra write
   always @(negedge clk) begin
      if (imem_we) iq.push_back({imem_addr, imem_wdata});
      if (dmem_we) dq.push_back({dmem_addr, dmem_wdata});
   end

   task automatic sb(input logic [7:0] b);
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_seq;
      foreach (seq[i]) sb(seq[i]);
   endtask

   task automatic do_reset;
      rx_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      iq.delete();
      dq.delete();
   endtask

   task automatic test_reset;
      do_reset();
      total++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready got %b exp 1", rx_ready); else passed++;
      total++; if (core_hold !== 1'b1) $display("FAIL reset_core_hold got %b exp 1", core_hold); else passed++;
      total++; if (start_pc !== 32'h0) $display("FAIL reset_start_pc got %h exp 0", start_pc); else passed++;
      total++; if ({load_done, load_error} !== 2'b00) $display("FAIL reset_status got %b exp 00", {load_done, load_error}); else passed++;
      total++; if ({imem_we, dmem_we} !== 2'b00) $display("FAIL reset_we got %b exp 00", {imem_we, dmem_we}); else passed++;
      total++; if ({imem_addr, imem_wdata, dmem_addr, dmem_wdata} !== 128'h0)
         $display("FAIL reset_bus got %h exp 0", {imem_addr, imem_wdata, dmem_addr, dmem_wdata}); else passed++;
   endtask

   task automatic test_instr_block;
      do_reset();
      seq = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'h28, 8'h00, 8'h02,
              8'h20, 8'h08, 8'h00, 8'h02, 8'h20, 8'h09, 8'h00, 8'h02, 8'h28};
      foreach (seq[i]) begin
         sb(seq[i]);
         if (i == 10) begin
            total++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h328, 32'h20080002})
               $display("FAIL instr_first_write got %b %h %h exp 1 328 20080002", imem_we, imem_addr, imem_wdata); else passed++;
         end
         if (i == 11) begin
            total++; if (imem_we !== 1'b0) $display("FAIL instr_pulse_width got %b exp 0", imem_we); else passed++;
         end
      end
      @(posedge clk); #1;
      total++; if (iq.size() != 2 || iq[0] !== {32'h328, 32'h20080002} || iq[1] !== {32'h32C, 32'h20090002})
         $display("FAIL instr_writes got n=%0d %h %h exp 2 writes 328/32C", iq.size(), iq.size() > 0 ? iq[0] : 64'h0, iq.size() > 1 ? iq[1] : 64'h0); else passed++;
      total++; if (dq.size() != 0) $display("FAIL instr_no_dmem got %0d exp 0", dq.size()); else passed++;
      total++; if ({rx_ready, core_hold, load_error} !== 3'b110) $display("FAIL instr_idle got %b exp 110", {rx_ready, core_hold, load_error}); else passed++;
   endtask

   task automatic test_go;
      seq = '{8'h3C, 8'h00, 8'h00, 8'h03, 8'h28};
      send_seq();
      total++; if (start_pc !== 32'd808) $display("FAIL go_start_pc got %0d exp 808", start_pc); else passed++;
      total++; if ({load_done, core_hold, rx_ready} !== 3'b100) $display("FAIL go_release got %b exp 100", {load_done, core_hold, rx_ready}); else passed++;
      seq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      send_seq();
      @(posedge clk); #1;
      total++; if (iq.size() != 2 || dq.size() != 0 || load_done !== 1'b1 || rx_ready !== 1'b0)
         $display("FAIL go_sticky got i=%0d d=%0d done=%b rdy=%b exp 2 0 1 0", iq.size(), dq.size(), load_done, rx_ready); else passed++;
   endtask

   task automatic test_bad_csum;
      do_reset();
      seq = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h1A, 8'h00};
      send_seq();
      @(posedge clk); #1;
      total++; if (dq.size() != 1 || dq[0] !== {32'h0, 32'h1A})
         $display("FAIL csum_dwrite got n=%0d %h exp 1 write 0/1A", dq.size(), dq.size() > 0 ? dq[0] : 64'h0); else passed++;
      total++; if ({load_error, core_hold, rx_ready} !== 3'b110) $display("FAIL csum_error got %b exp 110", {load_error, core_hold, rx_ready}); else passed++;
      seq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
      send_seq();
      @(posedge clk); #1;
      total++; if (iq.size() != 0 || dq.size() != 1 || load_error !== 1'b1)
         $display("FAIL csum_ignored got i=%0d d=%0d err=%b exp 0 1 1", iq.size(), dq.size(), load_error); else passed++;
   endtask

   task automatic test_bad_cmd;
      do_reset();
      sb(8'h77);
      total++; if ({load_error, core_hold, rx_ready} !== 3'b110) $display("FAIL badcmd_error got %b exp 110", {load_error, core_hold, rx_ready}); else passed++;
      @(posedge clk); #1;
      total++; if (iq.size() + dq.size() != 0) $display("FAIL badcmd_writes got %0d exp 0", iq.size() + dq.size()); else passed++;
   endtask

   task automatic test_wrap_and_empty;
      do_reset();
      seq = '{8'h5A, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'h00, 8'h02,
              8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h01};
      send_seq();
      @(posedge clk); #1;
      total++; if (dq.size() != 2 || dq[0] !== {32'hFFFFFFFC, 32'h11111111} || dq[1] !== {32'h0, 32'h22222222})
         $display("FAIL wrap_writes got n=%0d %h %h exp FFFFFFFC then 0", dq.size(), dq.size() > 0 ? dq[0] : 64'h0, dq.size() > 1 ? dq[1] : 64'h0); else passed++;
      total++; if ({rx_ready, load_error} !== 2'b10) $display("FAIL wrap_idle got %b exp 10", {rx_ready, load_error}); else passed++;
      dq.delete();
      seq = '{8'h5A, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'h00, 8'h00, 8'h03};
      send_seq();
      @(posedge clk); #1;
      total++; if (iq.size() + dq.size() != 0 || {rx_ready, load_error} !== 2'b10)
         $display("FAIL empty_block got writes=%0d st=%b exp 0 10", iq.size() + dq.size(), {rx_ready, load_error}); else passed++;
   endtask

   task automatic test_count_limit;
      do_reset();
      seq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
      send_seq();
      total++; if ({rx_ready, load_error} !== 2'b10) $display("FAIL count_max_ok got %b exp 10", {rx_ready, load_error}); else passed++;
      do_reset();
      seq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h01};
      send_seq();
      total++; if ({rx_ready, load_error} !== 2'b01) $display("FAIL count_over got %b exp 01", {rx_ready, load_error}); else passed++;
   endtask

   task automatic test_back_to_back;
      for (int pass = 0; pass < 2; pass++) begin
         gaps = (pass == 1);
         do_reset();
         seq = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD};
         send_seq();
         rst_n = 1'b0;
         @(posedge clk); #1;
         total++; if ({imem_we, dmem_we} !== 2'b00) $display("FAIL midreset_we pass%0d got %b exp 00", pass, {imem_we, dmem_we}); else passed++;
         rst_n = 1'b1;
         @(posedge clk); #1;
         total++; if (iq.size() + dq.size() != 0) $display("FAIL midreset_spurious pass%0d got %0d exp 0", pass, iq.size() + dq.size()); else passed++;
         seq = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
         send_seq();
         @(posedge clk); #1;
         total++; if (iq.size() != 1 || iq[0] !== {32'h100, 32'hDEADBEEF} || dq.size() != 0)
            $display("FAIL reload pass%0d got n=%0d %h exp 1 write 100/DEADBEEF", pass, iq.size(), iq.size() > 0 ? iq[0] : 64'h0); else passed++;
         total++; if ({rx_ready, load_error} !== 2'b10) $display("FAIL reload_idle pass%0d got %b exp 10", pass, {rx_ready, load_error}); else passed++;
      end
      gaps = 1'b0;
   endtask

   initial begin
      test_reset();
      test_instr_block();
      test_go();
      test_bad_csum();
      test_bad_cmd();
      test_wrap_and_empty();
      test_count_limit();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
